// File: rtl/imem_burst_responder.sv
// Instruction-store line-fill responder: streams BURST_LEN ascending words per held-high request.
// Latency: first beat FIRST_BEAT_LATENCY cycles after accept, then one beat every BEAT_GAP+1 cycles.
// No backpressure; request must stay high until after o_Last. IMEM_PROTOCOL_CHECK_EN builds the checker.
module imem_burst_responder #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 22,
    parameter int BURST_LEN_WIDTH    = 2,
    parameter int MEM_DEPTH_WIDTH    = 10,
    parameter int FIRST_BEAT_LATENCY = 4,
    parameter int BEAT_GAP           = 0
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset_n,
    input  logic                       i_Valid,
    input  logic [ADDRESS_WIDTH-1:0]   i_Address,
    output logic                       o_Valid,
    output logic                       o_Last,
    output logic [DATA_WIDTH-1:0]      o_Data,
    output logic                       o_Busy,
    input  logic                       i_Load_Valid,
    input  logic [MEM_DEPTH_WIDTH-1:0] i_Load_Address,
    input  logic [DATA_WIDTH-1:0]      i_Load_Data,
    output logic                       o_Protocol_Error
);
    localparam int LINE_WIDTH = MEM_DEPTH_WIDTH - BURST_LEN_WIDTH;

    typedef enum logic [2:0] {IDLE, LATENCY, STREAM, GAP, DRAIN} state_t;

    state_t                      state;
    logic [3:0]                  cnt;
    logic [LINE_WIDTH-1:0]       line;
    logic [BURST_LEN_WIDTH-1:0]  beat;
    logic [DATA_WIDTH-1:0]       mem [1<<MEM_DEPTH_WIDTH];
    logic [MEM_DEPTH_WIDTH-1:0]  rd_addr;
    logic [LINE_WIDTH-1:0]       req_line;
    logic                        last_beat;
    logic                        emit;
    logic                        unused_addr_bits;

    // Line index drops the byte bit, the in-line beat bits and anything above the store depth.
    assign req_line  = i_Address[MEM_DEPTH_WIDTH:BURST_LEN_WIDTH+1];
    assign rd_addr   = {line, beat};
    assign last_beat = (beat == '1);
    assign emit      = ((state == LATENCY) && (cnt == '0)) ||
                       ((state == STREAM) && (BEAT_GAP == 0)) ||
                       ((state == GAP) && (cnt == '0));
    assign unused_addr_bits = ^{i_Address[0], i_Address[ADDRESS_WIDTH-1:MEM_DEPTH_WIDTH+1]};

    // Non-blocking write keeps a same-cycle read returning the old word.
    always_ff @(posedge i_Clk) begin
        if (i_Load_Valid) begin
            mem[i_Load_Address] <= i_Load_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            line    <= '0;
            beat    <= '0;
            o_Valid <= 1'b0;
            o_Last  <= 1'b0;
            o_Data  <= '0;
            o_Busy  <= 1'b0;
        end else begin
            o_Valid <= 1'b0;
            o_Last  <= 1'b0;
            o_Data  <= '0;
            if (emit) begin
                o_Valid <= 1'b1;
                o_Last  <= last_beat;
                o_Data  <= mem[rd_addr];
                beat    <= beat + 1'b1;
                state   <= last_beat ? DRAIN : STREAM;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_Valid) begin
                            line   <= req_line;
                            beat   <= '0;
                            cnt    <= 4'(FIRST_BEAT_LATENCY - 1);
                            state  <= LATENCY;
                            o_Busy <= 1'b1;
                        end
                    end
                    LATENCY: cnt <= cnt - 1'b1;
                    // Only reached with a nonzero gap; zero gap always emits from STREAM.
                    STREAM: begin
                        cnt   <= 4'(BEAT_GAP - 1);
                        state <= GAP;
                    end
                    GAP: cnt <= cnt - 1'b1;
                    DRAIN: begin
                        if (!i_Valid) begin
                            state  <= IDLE;
                            o_Busy <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IMEM_PROTOCOL_CHECK_EN
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic                     active;
    logic                     viol;
    logic                     perr;

    assign active = (state == LATENCY) || (state == STREAM) || (state == GAP);
    assign viol   = active && (!i_Valid || (i_Address != req_addr) ||
                    (i_Load_Valid && (i_Load_Address[MEM_DEPTH_WIDTH-1:BURST_LEN_WIDTH] == line)));

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            req_addr <= '0;
            perr     <= 1'b0;
        end else begin
            if ((state == IDLE) && i_Valid) begin
                req_addr <= i_Address;
            end
            if (viol) begin
                perr <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge i_Clk) begin
        if (i_Reset_n && viol) begin
            $display("%0t imem_burst_responder: protocol violation", $time);
        end
    end
`endif

    assign o_Protocol_Error = perr;
`else
    assign o_Protocol_Error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_burst_responder.sv
// Directed bench for imem_burst_responder: default timing instance plus a latency-1 / gap-2 instance.
module tb_imem_burst_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld, g_vld;
    logic [21:0] addr, g_addr;
    logic        ld_vld;
    logic [9:0]  ld_addr;
    logic [31:0] ld_dat;
    logic        o_vld, o_last, o_busy, o_perr;
    logic [31:0] o_dat;
    logic        g_ovld, g_olast, g_obusy, g_operr;
    logic [31:0] g_odat;

    int          checks = 0;
    int          errors = 0;
    int          nbeats;
    int          cap_c [4];
    logic [31:0] cap_d [4];
    logic [3:0]  cap_l;

    always #5 clk = ~clk;

    imem_burst_responder dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Valid(vld), .i_Address(addr),
        .o_Valid(o_vld), .o_Last(o_last), .o_Data(o_dat), .o_Busy(o_busy),
        .i_Load_Valid(ld_vld), .i_Load_Address(ld_addr), .i_Load_Data(ld_dat),
        .o_Protocol_Error(o_perr)
    );

    imem_burst_responder #(.FIRST_BEAT_LATENCY(1), .BEAT_GAP(2)) dut_g (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Valid(g_vld), .i_Address(g_addr),
        .o_Valid(g_ovld), .o_Last(g_olast), .o_Data(g_odat), .o_Busy(g_obusy),
        .i_Load_Valid(ld_vld), .i_Load_Address(ld_addr), .i_Load_Data(ld_dat),
        .o_Protocol_Error(g_operr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_vld  = 1'b1;
        ld_addr = a;
        ld_dat  = d;
        @(negedge clk);
        ld_vld  = 1'b0;
    endtask

    // Sample each negedge after the accept edge; c counts cycles after accept.
    task automatic capture(input bit gsel, input int budget);
        bit done;
        done   = 1'b0;
        nbeats = 0;
        cap_l  = '0;
        for (int k = 0; k < 4; k++) begin
            cap_c[k] = -1;
            cap_d[k] = '0;
        end
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (gsel ? g_ovld : o_vld) begin
                if (nbeats < 4) begin
                    cap_c[nbeats] = c;
                    cap_d[nbeats] = gsel ? g_odat : o_dat;
                    cap_l[nbeats] = gsel ? g_olast : o_last;
                end
                nbeats++;
                if (gsel ? g_olast : o_last) done = 1'b1;
            end
        end
        check("burst_done", 32'(done), 32'd1);
    endtask

    task automatic check_burst(input string tag, input int c0, input int step, input logic [31:0] d0);
        check({tag, "_nbeats"}, 32'(nbeats), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_cyc%0d", tag, k), 32'(cap_c[k]), 32'(c0 + k * step));
            check($sformatf("%s_dat%0d", tag, k), cap_d[k], d0 + 32'(k));
        end
        check({tag, "_last"}, 32'(cap_l), 32'b1000);
    endtask

    task automatic finish_burst();
        vld = 1'b0;
        @(negedge clk);
        check("busy_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int extra;
        rst_n = 1'b0; vld = 1'b0; g_vld = 1'b0; addr = '0; g_addr = '0;
        ld_vld = 1'b0; ld_addr = '0; ld_dat = '0;
        repeat (3) @(negedge clk);
        check("rst_vld",  32'(o_vld),  32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_dat",  o_dat,       32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_perr", 32'(o_perr), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            load(10'h010 + 10'(k), 32'hA0 + 32'(k));
            load(10'h3FC + 10'(k), 32'hB0 + 32'(k));
        end

        // Aligned request at word 0x10.
        @(negedge clk); vld = 1'b1; addr = 22'h000020;
        capture(1'b0, 30);
        check_burst("aligned", 4, 1, 32'hA0);
        check("busy_drain", 32'(o_busy), 32'd1);
        finish_burst();

        // Unaligned request at word 0x13 still returns the line in order.
        @(negedge clk); vld = 1'b1; addr = 22'h000026;
        capture(1'b0, 30);
        check_burst("unaligned", 4, 1, 32'hA0);
        finish_burst();

        // Top line of the store.
        @(negedge clk); vld = 1'b1; addr = 22'h0007F8;
        capture(1'b0, 30);
        check_burst("top", 4, 1, 32'hB0);
        finish_burst();

        // Word 0x100010 truncates to 0x010.
        @(negedge clk); vld = 1'b1; addr = 22'h200020;
        capture(1'b0, 30);
        check_burst("wrap", 4, 1, 32'hA0);
        finish_burst();

        // Request held after o_Last must not restart until dropped.
        @(negedge clk); vld = 1'b1; addr = 22'h000020;
        capture(1'b0, 30);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_vld) extra++;
        end
        check("hold_no_burst", 32'(extra), 32'd0);
        check("hold_busy", 32'(o_busy), 32'd1);
        vld = 1'b0;
        @(negedge clk);
        check("drop_idle", 32'(o_busy), 32'd0);
        vld = 1'b1;
        capture(1'b0, 30);
        check_burst("rehold", 4, 1, 32'hA0);
        finish_burst();

        // Address change after accept is ignored.
        @(negedge clk); vld = 1'b1; addr = 22'h000020;
        repeat (2) @(negedge clk);
        addr = 22'h0007F8;
        capture(1'b0, 30);
        check_burst("addr_chg", 2, 1, 32'hA0);
`ifdef IMEM_PROTOCOL_CHECK_EN
        check("perr_set", 32'(o_perr), 32'd1);
`else
        check("perr_tied", 32'(o_perr), 32'd0);
`endif
        finish_burst();

        // Latency 1, gap 2 instance.
        @(negedge clk); g_vld = 1'b1; g_addr = 22'h000020;
        capture(1'b1, 40);
        check_burst("gap", 1, 3, 32'hA0);
        check("gap_busy_drain", 32'(g_obusy), 32'd1);
        g_vld = 1'b0;
        @(negedge clk);
        check("gap_busy_idle", 32'(g_obusy), 32'd0);

        // Reset during beat 2, then a fresh full burst.
        @(negedge clk); vld = 1'b1; addr = 22'h000020;
        repeat (7) @(negedge clk);
        check("pre_rst_vld", 32'(o_vld), 32'd1);
        check("pre_rst_dat", o_dat, 32'hA2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  32'(o_vld),  32'd0);
        check("mid_rst_last", 32'(o_last), 32'd0);
        check("mid_rst_dat",  o_dat,       32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); vld = 1'b1; addr = 22'h000020;
        capture(1'b0, 30);
        check_burst("post_rst", 4, 1, 32'hA0);
        finish_burst();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_burst_responder.md
Name: imem_burst_responder

Overview:
- Memory-side responder for the instruction-cache line-fill interface.
- Accepts a held-high line request and streams BURST_LEN consecutive words from an internal word-addressed instruction store, flagging the final beat with o_Last.
- Sits between the I-cache miss port and the instruction memory; a side load port lets the testbench or boot logic write the store.

Parameters:
- DATA_WIDTH, 32, width of one word/beat.
- ADDRESS_WIDTH, 22, request address width; bit 0 ignored, word address = i_Address[ADDRESS_WIDTH-1:1].
- BURST_LEN_WIDTH, 2, log2 of beats per line; BURST_LEN = 1<<BURST_LEN_WIDTH (4).
- MEM_DEPTH_WIDTH, 10, log2 of store depth in words.
- FIRST_BEAT_LATENCY, 4, cycles from request accept edge to first beat; legal range 1..15.
- BEAT_GAP, 0, idle cycles inserted between consecutive beats; legal range 0..15.

Ports:
- i_Clk  in  1  clock.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_Valid  in  1  line request; held high by the requester until after the last beat.
- i_Address  in  ADDRESS_WIDTH  line request address.
- o_Valid  out  1  beat valid.
- o_Last  out  1  final beat of the burst; only high with o_Valid.
- o_Data  out  DATA_WIDTH  beat data.
- o_Busy  out  1  high in any state other than IDLE.
- i_Load_Valid  in  1  store write strobe.
- i_Load_Address  in  MEM_DEPTH_WIDTH  store write word address.
- i_Load_Data  in  DATA_WIDTH  store write data.
- o_Protocol_Error  out  1  sticky protocol-violation flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock, i_Clk; reset is asynchronous and active-low on i_Reset_n.
- Reset values: o_Valid=0, o_Last=0, o_Data=0, o_Busy=0, o_Protocol_Error=0, state=IDLE. Store contents are not reset.
- All outputs are registered. o_Data is 0 in any cycle with o_Valid=0.
- Base word address = i_Address[ADDRESS_WIDTH-1:1] truncated to MEM_DEPTH_WIDTH bits, with the low BURST_LEN_WIDTH bits forced to 0.
- Beat k reads base+k for k=0..BURST_LEN-1. Beats are always in ascending order, never critical-word-first.
- Store addresses wrap modulo 2^MEM_DEPTH_WIDTH.
- IDLE: a rising edge with i_Valid=1 latches the base, loads the delay counter and enters LATENCY.
- LATENCY: the first beat appears exactly FIRST_BEAT_LATENCY cycles after the accept edge. With latency 1, o_Valid is high in the cycle right after accept.
- STREAM: one beat per cycle when BEAT_GAP=0. Otherwise STREAM and GAP alternate, with BEAT_GAP idle cycles between beats.
- Last beat: o_Last=1 on beat BURST_LEN-1; the next state is DRAIN.
- DRAIN: stays until i_Valid is sampled 0, then returns to IDLE. A request still held high after o_Last must never start a second burst.
- Request changes mid-burst: i_Valid dropping or i_Address changing mid-burst is ignored. The burst completes from the latched base.
- Load writes: accepted in every state, one word per cycle.
- Same-cycle read and write of one word: the read returns the old data (read-before-write). The new value is visible from the next read.
- Reset asserted mid-burst: outputs clear immediately and the state returns to IDLE. No partial o_Last is emitted.

Optional Feature:
- Macro: IMEM_PROTOCOL_CHECK_EN.
- Defined: o_Protocol_Error sets and stays set until reset on any of these:
  - i_Valid drops while the state is LATENCY, STREAM or GAP.
  - i_Address differs from the latched request at any sampled edge before o_Last.
  - i_Load_Valid targets a word in the active burst.
  - A simulation $display warning is also printed with $time.
- Not defined: o_Protocol_Error is tied to 0 and no check logic is built. The data path behaves identically either way.

Test Plan:
- Reset, load words 0x10..0x13 with 0xA0..0xA3, request address 0x000020 (word 0x10), latency 4, gap 0 -> o_Valid high on cycles 4..7 after accept, data A0,A1,A2,A3, o_Last only with A3.
- Request address 0x000026 (word 0x13, unaligned) -> the burst still returns words 0x10..0x13 in order.
- Hold i_Valid high for 5 cycles after o_Last, then drop for 1 cycle and raise again -> exactly one extra burst, starting only after the drop; no burst occurs during the hold.
- BEAT_GAP=2, FIRST_BEAT_LATENCY=1 -> beats on cycles 1, 4, 7, 10 after accept; o_Busy stays high through DRAIN.
- Request at top word 0x3FC with depth 1024 -> reads 0x3FC..0x3FF. Separately, a request whose truncated base wraps -> correct modulo addresses.
- Assert i_Reset_n low during beat 2 -> o_Valid, o_Last and o_Data are 0 immediately, and a fresh request after release returns a full 4-beat burst. With IMEM_PROTOCOL_CHECK_EN, changing i_Address mid-burst sets o_Protocol_Error=1.
